// File: rtl/traffic_pkg.sv
// traffic_pkg: definitions shared by the intersection light controller and the
// lane sensor front-end.
//   NUM_LANES               number of served lanes
//   ctrl_state_e            light-controller state encoding
//   light_signal_e          per-lane lamp codes
//   DEF_DEBOUNCE_CYC,
//   DEF_CONG_HI, DEF_CONG_LO default debounce length and congestion thresholds
package traffic_pkg;

    localparam int unsigned NUM_LANES = 2;

    typedef enum logic [1:0] {
        CTRL_L0_GO   = 2'd0,
        CTRL_L0_WARN = 2'd1,
        CTRL_L1_GO   = 2'd2,
        CTRL_L1_WARN = 2'd3
    } ctrl_state_e;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'd0,
        LIGHT_YELLOW = 2'd1,
        LIGHT_GREEN  = 2'd2
    } light_signal_e;

    localparam int unsigned DEF_DEBOUNCE_CYC = 4;
    localparam int unsigned DEF_CONG_HI      = 3;
    localparam int unsigned DEF_CONG_LO      = 1;

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchroniser, debouncer and rising-edge pulse for a
// single raw detector input.
//   clk_i    system clock, rising edge
//   rst_ni   asynchronous active-low reset
//   raw_i    raw detector level, asynchronous to clk_i
//   level_o  accepted (debounced) level, registered
//   rise_o   one-cycle pulse, registered, on the accepted level's 0->1 change
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic [7:0] stab_q, stab_d;
    logic       level_q, level_d;
    logic       rise_q, rise_d;

    // The flip happens on the edge whose sample brings the run of differing
    // samples to DEBOUNCE_CYC, i.e. when the counter already holds DEBOUNCE_CYC-1.
    always_comb begin
        stab_d  = stab_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_q[1] == level_q) begin
            stab_d = '0;
        end else if (stab_q == 8'(DEBOUNCE_CYC - 1)) begin
            stab_d  = '0;
            level_d = ~level_q;
            rise_d  = ~level_q;
        end else begin
            stab_d = stab_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            stab_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            stab_q  <= stab_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/lane_sensor_conditioner.sv
// lane_sensor_conditioner: conditions raw entry/exit loop detectors for each
// lane and produces the S1 (presence) and S5 (congestion) flags for the light
// controller, plus per-lane occupancy counts.
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   det_entry  raw entry-loop detector per lane
//   det_exit   raw exit-loop detector per lane
//   S1         lane presence flag per lane, registered
//   S5         lane congestion flag per lane (hysteretic), registered
//   occ_cnt    occupancy counts, lane 0 in the low CNT_W bits
//   det_fault  stuck-entry-detector flag per lane
// Optional feature: define LANE_SENSOR_STUCK_DET_EN to build the stuck-entry
// detector; otherwise det_fault is constant 0.
module lane_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned CONG_HI      = DEF_CONG_HI,
    parameter int unsigned CONG_LO      = DEF_CONG_LO,
    parameter int unsigned STUCK_CYC    = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LANES-1:0]       det_entry,
    input  logic [NUM_LANES-1:0]       det_exit,
    output logic [NUM_LANES-1:0]       S1,
    output logic [NUM_LANES-1:0]       S5,
    output logic [NUM_LANES*CNT_W-1:0] occ_cnt,
    output logic [NUM_LANES-1:0]       det_fault
);

    logic [NUM_LANES-1:0] entry_rise, exit_rise;
    logic [NUM_LANES-1:0] entry_lvl, exit_lvl_unused;
    logic [NUM_LANES-1:0] fault;

    logic [CNT_W-1:0]     cnt_q [NUM_LANES];
    logic [CNT_W-1:0]     cnt_d [NUM_LANES];
    logic [NUM_LANES-1:0] s1_q, s1_d;
    logic [NUM_LANES-1:0] s5_q, s5_d;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_entry (
            .clk_i   (clk),
            .rst_ni  (rst),
            .raw_i   (det_entry[g]),
            .level_o (entry_lvl[g]),
            .rise_o  (entry_rise[g])
        );
        sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_exit (
            .clk_i   (clk),
            .rst_ni  (rst),
            .raw_i   (det_exit[g]),
            .level_o (exit_lvl_unused[g]),
            .rise_o  (exit_rise[g])
        );
        assign occ_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    always_comb begin
        cnt_d = cnt_q;
        s5_d  = s5_q;
        s1_d  = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            // Simultaneous entry and exit pulses cancel.
            if (entry_rise[i] && !exit_rise[i] && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (exit_rise[i] && !entry_rise[i] && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
            // Between the thresholds S5 keeps its previous value.
            if (cnt_q[i] >= CNT_W'(CONG_HI)) begin
                s5_d[i] = 1'b1;
            end else if (cnt_q[i] <= CNT_W'(CONG_LO)) begin
                s5_d[i] = 1'b0;
            end
            s1_d[i] = (cnt_q[i] != '0) || fault[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                cnt_q[i] <= '0;
            end
            s1_q <= '0;
            s5_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            s1_q  <= s1_d;
            s5_q  <= s5_d;
        end
    end

`ifdef LANE_SENSOR_STUCK_DET_EN
    localparam int unsigned STUCK_W = $clog2(STUCK_CYC + 1);

    logic [STUCK_W-1:0]   stuck_q [NUM_LANES];
    logic [NUM_LANES-1:0] fault_q;

    // Fault is sticky until reset; the run counter saturates once it reaches
    // STUCK_CYC so a long-held detector cannot wrap it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                stuck_q[i] <= '0;
            end
            fault_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (!entry_lvl[i]) begin
                    stuck_q[i] <= '0;
                end else if (stuck_q[i] != STUCK_W'(STUCK_CYC)) begin
                    stuck_q[i] <= stuck_q[i] + 1'b1;
                end
                if (entry_lvl[i] && stuck_q[i] == STUCK_W'(STUCK_CYC - 1)) begin
                    fault_q[i] <= 1'b1;
                end
            end
        end
    end

    assign fault = fault_q;
`else
    localparam int unsigned STUCK_CYC_UNUSED = STUCK_CYC;
    logic entry_lvl_unused;

    assign entry_lvl_unused = ^entry_lvl;
    assign fault            = '0;
`endif

    assign S1        = s1_q;
    assign S5        = s5_q;
    assign det_fault = fault;

endmodule

// File: doc/lane_sensor_conditioner.md
Name: lane_sensor_conditioner

Overview:
Front-end that produces the per-lane sensor flags consumed by the intersection light controller. The flags are S1 (vehicle present at start of lane) and S5 (lane congested). The block synchronises and debounces raw inductive-loop detector inputs for two lanes, then tracks a per-lane vehicle occupancy count from entry/exit loops. It derives presence and hysteretic congestion flags from that count. It sits between the pad-level detector inputs and the light controller's S1/S5 inputs.

Parameters:
DEBOUNCE_CYC, 4, consecutive stable synchronised samples required before a detector level is accepted (1..255)
CNT_W, 4, width of the per-lane occupancy counter
CONG_HI, 3, occupancy at or above which S5[i] sets
CONG_LO, 1, occupancy at or below which S5[i] clears (must be < CONG_HI)
STUCK_CYC, 1000, cycles of continuous debounced-high entry detector before fault (optional feature only)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
det_entry  input  2  raw entry-loop detector per lane, asynchronous to clk
det_exit  input  2  raw exit-loop detector per lane, asynchronous to clk
S1  output  2  lane presence flag per lane, registered
S5  output  2  lane congestion flag per lane, registered
occ_cnt  output  2*CNT_W  occupancy counts, lane 0 in low bits
det_fault  output  2  stuck-entry-detector flag per lane (constant 0 when feature compiled out)

Behaviour:
- Reset (rst low, asynchronous assert, synchronous release through normal flops): all synchroniser, debounce, counter and output flops go to 0. S1=0, S5=0, occ_cnt=0, det_fault=0. Reset mid-operation discards all counts; no residual state.
- Each of the 4 raw inputs passes through a 2-flop synchroniser, then a debouncer.
- Debouncer: holds an accepted level, initially 0. A stability counter counts consecutive synchronised samples differing from the accepted level. The counter clears whenever a sample equals the accepted level. When the counter reaches DEBOUNCE_CYC, the accepted level flips on that edge and the counter clears. Glitches shorter than DEBOUNCE_CYC samples are ignored.
- Edge detect: the block generates a one-cycle pulse on the accepted level's 0->1 transition only.
- Occupancy update (per lane, one edge after the pulse):
  - entry pulse only: +1, saturating at 2^CNT_W-1
  - exit pulse only: -1, saturating at 0
  - both in the same cycle: no change
- Outputs are registered from the count one edge later:
  - S1[i] = (cnt_i != 0)
  - S5[i] sets when cnt_i >= CONG_HI and clears when cnt_i <= CONG_LO. Between the two thresholds it holds its previous value.
- Latency: a clean raw entry rising edge first sampled at edge k yields its count increment at edge k+2+DEBOUNCE_CYC and S1/S5 update at edge k+3+DEBOUNCE_CYC.
- Lanes are fully independent; no cross-lane interaction.

Optional Feature:
Macro LANE_SENSOR_STUCK_DET_EN.
- Defined: a per-lane counter runs while the debounced entry level is 1 and clears when it is 0. On reaching STUCK_CYC, det_fault[i] sets and stays set until reset. While det_fault[i]=1, S1[i] is forced 1 (fail-safe: lane always served). S5[i] and the occupancy count are unaffected.
- Undefined: no counter logic is built, det_fault=0, and S1 follows occupancy only.

Decomposition:
- Shared package traffic_pkg: NUM_LANES=2, the light-controller state encodings and light_signal codes, and the default DEBOUNCE_CYC/CONG_HI/CONG_LO values used by both blocks.
- Sub-module sensor_debounce: synchroniser, debouncer and rising-edge pulse for one detector, parameterised by DEBOUNCE_CYC. Instantiated 4 times.
- Counter, hysteresis and stuck-detect logic stay in the top module.

Test Plan:
- Reset with det_entry=2'b11 held -> S1=0, S5=0, occ_cnt=0 during reset and for the first DEBOUNCE_CYC+2 edges after release.
- Lane0 entry high for 3 cycles, then low (glitch < 4) -> no count change; S1[0] stays 0.
- Lane0 clean entry rise first sampled at edge k -> occ_cnt lane0=1 at edge k+6; S1[0]=1 at edge k+7; S5[0]=0.
- Lane1: 3 entries -> S5[1]=1. Then 1 exit (cnt=2) -> S5[1] stays 1. Then 1 more exit (cnt=1) -> S5[1]=0 and S1[1]=1. Then a final exit -> S1[1]=0.
- Entry and exit pulses on the same cycle at cnt=2 -> cnt stays 2. Exit at cnt=0 -> stays 0. 16 entries with CNT_W=4 -> saturates at 15.
- With LANE_SENSOR_STUCK_DET_EN and STUCK_CYC=20: hold lane0 entry high -> det_fault[0]=1 after 20 debounced-high cycles and S1[0]=1 even after exits drain cnt to 0. Fault clears only on rst low.
